// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the keypad scanner:
//   - kp_state_e : debounce FSM states
//   - OP_*       : index of each direct operation pin on i_op_pins
//   - code_width : keycode width, 1 type bit + enough bits for the larger of
//                  the matrix key index and the operation index
// -----------------------------------------------------------------------------
package keypad_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_DB   = 2'd1,
      HELD       = 2'd2,
      RELEASE_DB = 2'd3
   } kp_state_e;

   localparam int OP_AC  = 0;
   localparam int OP_ADD = 1;
   localparam int OP_SUB = 2;
   localparam int OP_MUL = 3;
   localparam int OP_DIV = 4;
   localparam int OP_EQ  = 5;

   function automatic int code_width(input int rows, input int cols, input int n_ops);
      int key_w;
      int op_w;
      key_w = $clog2(rows * cols);
      op_w  = $clog2(n_ops);
      return (key_w > op_w) ? (1 + key_w) : (1 + op_w);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-in first-out queue with a registered head.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : enqueue push_data (dropped silently when full and not popping)
//   push_data   : WIDTH-bit data to enqueue
//   pop         : dequeue the head (ignored when empty)
//   head_data   : registered copy of the oldest entry, 0 when empty
//   head_valid  : registered "queue not empty"
//   full, empty : occupancy flags decoded from the count register
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             head_valid,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_r;
   logic [PTR_W-1:0] rd_r;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] head_r;
   logic             valid_r;

   logic             do_pop_s;
   logic             do_push_s;
   logic [CNT_W-1:0] cnt_n_s;
   logic [PTR_W-1:0] rd_n_s;
   logic [PTR_W-1:0] wr_n_s;
   logic [WIDTH-1:0] head_n_s;

   assign full       = (cnt_r == CNT_FULL);
   assign empty      = (cnt_r == '0);
   assign head_data  = head_r;
   assign head_valid = valid_r;

   // Next-state for pointers, count and the registered head.
   always_comb begin
      do_pop_s  = pop && (cnt_r != '0);
      // A full queue still accepts a push when the head leaves in the same cycle.
      do_push_s = push && ((cnt_r != CNT_FULL) || do_pop_s);

      case ({do_push_s, do_pop_s})
         2'b10:   cnt_n_s = cnt_r + CNT_ONE;
         2'b01:   cnt_n_s = cnt_r - CNT_ONE;
         default: cnt_n_s = cnt_r;
      endcase

      rd_n_s = do_pop_s  ? (rd_r + PTR_ONE) : rd_r;
      wr_n_s = do_push_s ? (wr_r + PTR_ONE) : wr_r;

      // When the incoming word becomes the only entry it bypasses the array.
      if (cnt_n_s == '0) begin
         head_n_s = '0;
      end else if (do_push_s && (cnt_n_s == CNT_ONE)) begin
         head_n_s = push_data;
      end else begin
         head_n_s = mem_r[rd_n_s];
      end
   end

   // Storage array write port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (do_push_s) begin
         mem_r[wr_r] <= push_data;
      end
   end

   // Pointer, count and head registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_r    <= '0;
         rd_r    <= '0;
         cnt_r   <= '0;
         head_r  <= '0;
         valid_r <= 1'b0;
      end else begin
         wr_r    <= wr_n_s;
         rd_r    <= rd_n_s;
         cnt_r   <= cnt_n_s;
         head_r  <= head_n_s;
         valid_r <= (cnt_n_s != '0);
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a ROWS x COLS key matrix one row per cycle, merges in the direct
// operation buttons, debounces over whole scan passes and queues one keycode
// per debounced press/release cycle.
//   clk, rst_n     : clock, asynchronous active-low reset
//   o_word_lines   : one-hot row drive (row 0 after reset)
//   i_bit_lines    : column sense for the currently driven row
//   i_op_pins      : active-high operation buttons (OP_AC..OP_EQ)
//   o_data         : keycode at the queue head ({0,row*COLS+col} or {1,op})
//   o_data_valid   : queue not empty
//   i_read_ready   : consumer takes the head when o_data_valid is high
//   o_overflow     : one-cycle pulse when a keycode is dropped on a full queue
// -----------------------------------------------------------------------------
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter  int ROWS            = 4,
   parameter  int COLS            = 4,
   parameter  int N_OPS           = 6,
   parameter  int DEBOUNCE_PASSES = 2,
   parameter  int FIFO_DEPTH      = 4,
   localparam int CODE_W          = code_width(ROWS, COLS, N_OPS)
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ROWS-1:0]   o_word_lines,
   input  logic [COLS-1:0]   i_bit_lines,
   input  logic [N_OPS-1:0]  i_op_pins,
   output logic [CODE_W-1:0] o_data,
   output logic              o_data_valid,
   input  logic              i_read_ready,
   output logic              o_overflow
);

   localparam int ROW_W = $clog2(ROWS);
   localparam int COL_W = $clog2(COLS);
   localparam int OP_W  = (N_OPS > 1) ? $clog2(N_OPS) : 1;
   localparam int IDX_W = CODE_W - 1;
   localparam int CNT_W = $clog2(DEBOUNCE_PASSES + 1);

   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
   localparam logic [ROW_W-1:0] ROW_ONE   = ROW_W'(1);
   localparam logic [ROWS-1:0]  WORD_INIT = ROWS'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] DB_TARGET = CNT_W'(DEBOUNCE_PASSES);

   // Row scan
   logic [ROW_W-1:0]  row_r;
   logic [ROWS-1:0]   word_r;
   logic              last_row_s;

   // Per-cycle decode
   logic [COL_W-1:0]  col_idx_s;
   logic [OP_W-1:0]   op_idx_s;
   logic              num_any_s;
   logic              op_any_s;
   logic              press_s;
   logic [IDX_W-1:0]  num_idx_s;
   logic [CODE_W-1:0] cur_code_s;

   // Pass accumulation
   logic              hit_acc_r;
   logic [CODE_W-1:0] cand_acc_r;
   logic              pass_hit_s;
   logic [CODE_W-1:0] pass_cand_s;

   // Debounce FSM
   kp_state_e         state_r;
   kp_state_e         state_n_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  cnt_n_s;
   logic [CNT_W-1:0]  cnt_inc_s;
   logic [CODE_W-1:0] held_r;
   logic [CODE_W-1:0] held_n_s;
   logic              push_s;

   // Queue interface
   logic              pop_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic              ovf_r;

   assign last_row_s   = (row_r == ROW_LAST);
   assign o_word_lines = word_r;
   assign o_overflow   = ovf_r;

   // Row counter with a matching one-hot drive register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_r  <= '0;
         word_r <= WORD_INIT;
      end else if (last_row_s) begin
         row_r  <= '0;
         word_r <= WORD_INIT;
      end else begin
         row_r  <= row_r + ROW_ONE;
         word_r <= {word_r[ROWS-2:0], word_r[ROWS-1]};
      end
   end

   // Highest sensed column and lowest pressed operation pin this cycle.
   always_comb begin
      col_idx_s = '0;
      for (int c = 0; c < COLS; c++) begin
         col_idx_s = i_bit_lines[c] ? COL_W'(c) : col_idx_s;
      end
      op_idx_s = '0;
      for (int i = N_OPS - 1; i >= 0; i--) begin
         op_idx_s = i_op_pins[i] ? OP_W'(i) : op_idx_s;
      end
   end

   assign num_any_s = |i_bit_lines;
   assign op_any_s  = |i_op_pins;
   assign press_s   = num_any_s | op_any_s;
   assign num_idx_s = IDX_W'(row_r) * IDX_W'(COLS) + IDX_W'(col_idx_s);
   // Operation buttons win over a matrix key seen in the same cycle.
   assign cur_code_s = op_any_s ? {1'b1, IDX_W'(op_idx_s)} : {1'b0, num_idx_s};

   // The last row's own sample still counts toward the pass result.
   assign pass_hit_s  = hit_acc_r | press_s;
   assign pass_cand_s = hit_acc_r ? cand_acc_r : cur_code_s;

   // Accumulate the pass result; keep the code from the first pressed cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_acc_r  <= 1'b0;
         cand_acc_r <= '0;
      end else if (last_row_s) begin
         hit_acc_r  <= 1'b0;
         cand_acc_r <= '0;
      end else if (!hit_acc_r && press_s) begin
         hit_acc_r  <= 1'b1;
         cand_acc_r <= cur_code_s;
      end
   end

   assign cnt_inc_s = cnt_r + CNT_ONE;

   // Debounce next-state; only evaluated on the last row of a pass.
   always_comb begin
      state_n_s = state_r;
      cnt_n_s   = cnt_r;
      held_n_s  = held_r;
      push_s    = 1'b0;
      if (last_row_s) begin
         case (state_r)
            IDLE: begin
               if (pass_hit_s) begin
                  // A single-pass debounce passes straight through PRESS_DB.
                  if (CNT_ONE == DB_TARGET) begin
                     state_n_s = HELD;
                     cnt_n_s   = '0;
                     held_n_s  = pass_cand_s;
                  end else begin
                     state_n_s = PRESS_DB;
                     cnt_n_s   = CNT_ONE;
                  end
               end else begin
                  state_n_s = IDLE;
                  cnt_n_s   = '0;
               end
            end
            PRESS_DB: begin
               if (!pass_hit_s) begin
                  state_n_s = IDLE;
                  cnt_n_s   = '0;
               end else if (cnt_inc_s == DB_TARGET) begin
                  state_n_s = HELD;
                  cnt_n_s   = '0;
                  held_n_s  = pass_cand_s;
               end else begin
                  cnt_n_s   = cnt_inc_s;
               end
            end
            HELD: begin
               if (pass_hit_s) begin
                  state_n_s = HELD;
               end else if (CNT_ONE == DB_TARGET) begin
                  state_n_s = IDLE;
                  cnt_n_s   = '0;
                  push_s    = 1'b1;
               end else begin
                  state_n_s = RELEASE_DB;
                  cnt_n_s   = CNT_ONE;
               end
            end
            RELEASE_DB: begin
               if (pass_hit_s) begin
                  state_n_s = HELD;
                  cnt_n_s   = '0;
               end else if (cnt_inc_s == DB_TARGET) begin
                  state_n_s = IDLE;
                  cnt_n_s   = '0;
                  push_s    = 1'b1;
               end else begin
                  cnt_n_s   = cnt_inc_s;
               end
            end
            default: begin
               state_n_s = IDLE;
               cnt_n_s   = '0;
            end
         endcase
      end else begin
         state_n_s = state_r;
      end
   end

   // Debounce state, pass counter and latched keycode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         cnt_r   <= '0;
         held_r  <= '0;
      end else begin
         state_r <= state_n_s;
         cnt_r   <= cnt_n_s;
         held_r  <= held_n_s;
      end
   end

   assign pop_s = i_read_ready & ~fifo_empty_s;

   // Flag a keycode that arrives on a full queue with nothing leaving.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_r <= 1'b0;
      end else begin
         ovf_r <= push_s & fifo_full_s & ~pop_s;
      end
   end

   sync_fifo #(
      .WIDTH (CODE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push_s),
      .push_data  (held_r),
      .pop        (pop_s),
      .head_data  (o_data),
      .head_valid (o_data_valid),
      .full       (fifo_full_s),
      .empty      (fifo_empty_s)
   );

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of scanned word lines (>=2).
REQ-002 SHALL have parameter COLS, default 4, number of sensed bit lines (>=2).
REQ-003 SHALL have parameter N_OPS, default 6, number of direct operation pins (>=1).
REQ-004 SHALL have parameter DEBOUNCE_PASSES, default 2, consecutive scan passes needed to accept a press or release (>=1).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, keycode queue depth (power of two, >=2).
REQ-006 SHALL derive CODE_W = 1 + max(clog2(ROWS*COLS), clog2(N_OPS)).
REQ-007 SHALL have port clk, input, 1, the single clock; all flops on rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port o_word_lines, output, ROWS, one-hot row drive.
REQ-010 SHALL have port i_bit_lines, input, COLS, column sense for the driven row.
REQ-011 SHALL have port i_op_pins, input, N_OPS, active-high operation buttons (index 0 = AC, 1 = ADD, 2 = SUB, 3 = MUL, 4 = DIV, 5 = EQ).
REQ-012 SHALL have port o_data, output, CODE_W, keycode at the FIFO head.
REQ-013 SHALL have port o_data_valid, output, 1, FIFO non-empty.
REQ-014 SHALL have port i_read_ready, input, 1, consumer accepts the head when it is high together with o_data_valid.
REQ-015 SHALL have port o_overflow, output, 1, one-cycle pulse when a keycode is dropped.

Function
REQ-016 Row counter SHALL increment each cycle from 0 to ROWS-1 and wrap to 0; o_word_lines SHALL be 1<<row.
REQ-017 A scan pass SHALL be ROWS cycles; the pass result ("hit") SHALL be the OR of all sampled presses, including the cycle with row = ROWS-1.
REQ-018 Number code SHALL be {1'b0, row*COLS + c}, where c is the highest set bit of i_bit_lines.
REQ-019 Op code SHALL be {1'b1, index of the lowest set i_op_pins bit}, zero-extended.
REQ-020 Within a pass, the candidate SHALL be taken from the first cycle that has any press; on that cycle an op press SHALL take priority over a number press.
REQ-021 The FSM SHALL have the states IDLE, PRESS_DB, HELD and RELEASE_DB, and SHALL update only at pass end.
REQ-022 IDLE: on hit, SHALL go to PRESS_DB with debounce count = 1; otherwise stay in IDLE.
REQ-023 PRESS_DB: on hit, SHALL increment the count; when the count reaches DEBOUNCE_PASSES, SHALL latch the candidate into held_code and go to HELD. On no hit, SHALL go to IDLE.
REQ-024 HELD: on no hit, SHALL go to RELEASE_DB with count = 1; held_code SHALL NOT change while in HELD.
REQ-025 RELEASE_DB: on no hit, SHALL increment the count; at DEBOUNCE_PASSES, SHALL push held_code and go to IDLE. On hit, SHALL return to HELD.
REQ-026 With DEBOUNCE_PASSES = 1, the PRESS_DB and RELEASE_DB states SHALL be left at the same pass end they are entered.
REQ-027 The push SHALL occur on the pass-end edge; o_data_valid SHALL be high the following cycle.
REQ-028 Pop SHALL occur on o_data_valid && i_read_ready; o_data and o_data_valid SHALL come from registers and SHALL hold stable until popped.
REQ-029 On a push when the FIFO is full and there is no pop: the code SHALL be dropped and o_overflow SHALL pulse high for 1 cycle.
REQ-030 On a push and pop in the same cycle when full: the push SHALL be accepted with no overflow.
REQ-031 On a push and pop in the same cycle when not empty: the count SHALL be unchanged.
REQ-032 FIFO order SHALL be first-in first-out; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-033 Keys pressed while in HELD or RELEASE_DB SHALL NOT generate additional codes (one code per debounced press/release cycle).

Reset
REQ-034 On rst_n low, row = 0 (o_word_lines = 1), FSM = IDLE, counts = 0, held_code = 0, FIFO empty, o_data = 0, o_data_valid = 0 and o_overflow = 0, asynchronously.
REQ-035 A reset asserted mid-press SHALL discard all state; a key still held after reset SHALL require a full press debounce before it is recognised.

Structure
REQ-036 Package keypad_pkg SHALL hold the FSM state enum, the op index constants (OP_AC..OP_EQ) and the CODE_W helper function.
REQ-037 The FIFO SHALL be a sub-module sync_fifo (WIDTH, DEPTH) with push/pop/full/empty ports; scan, debounce and FSM logic SHALL stay in keypad_scanner.

Verification (ROWS=4, COLS=4, N_OPS=6, DEBOUNCE_PASSES=2, FIFO_DEPTH=4)
REQ-038 Hold row 2 / col 1 for 3 passes, then release for 2 passes -> exactly one code 5'b01001, o_data_valid high the cycle after the 2nd release pass end, held until i_read_ready is asserted.
REQ-039 Press a key for 1 pass only -> no code pushed and the FSM returns to IDLE.
REQ-040 Press i_op_pins[1] together with row 0 / col 3 -> code 5'b10001.
REQ-041 Enter 5 keystrokes (codes 1,2,3,4,5) with i_read_ready = 0 -> 4 codes queued, o_overflow pulses once on the 5th; reading then yields 1,2,3,4.
REQ-042 With the FIFO full, push on the same cycle as a pop -> no overflow and the new code is queued last.
REQ-043 Assert rst_n low while in HELD, then release the key -> all outputs are 0 and no code is emitted.
